game_fsm_ctrl: RTL and testbench



---
 rtl/game_fsm_ctrl_if.sv | 33 +++
 rtl/game_fsm_ctrl.sv | 173 +++++++++++++++++
 tb/tb_game_fsm_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_fsm_ctrl_if.sv
// Command, preload, datapath and status bundle for the 2048 game controller.
// Boards are 4x4 cells of 12 bits; cell (row, col) sits at index row*4+col.
interface game_fsm_ctrl_if;
  logic                   start;
  logic                   dir_valid;
  logic [3:0]             direction;
  logic                   dir_ready;
  logic                   load_valid;
  logic [3:0][3:0][11:0]  load_board;
  logic [3:0]             mm_direction;
  logic [3:0][3:0][11:0]  mm_board_in;
  logic [3:0][3:0][11:0]  mm_board_out;
  logic [19:0]            mm_score_update;
  logic [3:0][3:0][11:0]  board;
  logic [19:0]            score;
  logic                   move_invalid;
  logic                   game_won;
  logic                   game_over;

  modport master (
    output start, dir_valid, direction, load_valid, load_board,
           mm_board_out, mm_score_update,
    input  dir_ready, mm_direction, mm_board_in, board, score,
           move_invalid, game_won, game_over
  );

  modport slave (
    input  start, dir_valid, direction, load_valid, load_board,
           mm_board_out, mm_score_update,
    output dir_ready, mm_direction, mm_board_in, board, score,
           move_invalid, game_won, game_over
  );
endinterface

// File: rtl/game_fsm_ctrl.sv
// 2048 sequencing controller: owns board and score, drives the external
// move/merge datapath, spawns LFSR-placed tiles and evaluates win/lose.
module game_fsm_ctrl (
  input  logic            clk,
  input  logic            rst_n,
  game_fsm_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, SPAWN_A, SPAWN_B, WAIT, APPLY, SPAWN, CHECK, LOST
  } state_t;

  state_t            state_q, state_d;
  logic [15:0][11:0] board_q, board_d;
  logic [19:0]       score_q, score_d;
  logic [3:0]        dir_q, dir_d;
  logic              dir_ready_q;
  logic              invalid_q, invalid_d;
  logic              won_q, won_d;
  logic              over_q, over_d;
  logic [15:0]       lfsr_q;

  logic [15:0][11:0] spawned;
  logic [15:0][11:0] mm_out;
  logic [15:0][11:0] load_flat;
  logic [20:0]       score_sum;
  logic              full, has_pair, has_win_tile;
  logic              accept;

  assign mm_out    = bus.mm_board_out;
  assign load_flat = bus.load_board;
  assign score_sum = {1'b0, score_q} + {1'b0, bus.mm_score_update};
  assign accept    = bus.dir_valid && dir_ready_q;

  // First empty cell at or after lfsr[3:0], wrapping; board unchanged if full.
  always_comb begin
    logic       found;
    logic [3:0] idx;
    spawned = board_q;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      idx = lfsr_q[3:0] + 4'(k);
      if (!found && board_q[idx] == '0) begin
        spawned[idx] = (lfsr_q[7:4] == 4'd0) ? 12'h004 : 12'h002;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    logic [3:0] i;
    full         = 1'b1;
    has_pair     = 1'b0;
    has_win_tile = 1'b0;
    i            = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        i = 4'(r * 4 + c);
        if (board_q[i] == '0)     full         = 1'b0;
        if (board_q[i] == 12'h800) has_win_tile = 1'b1;
        if (c < 3 && board_q[i] == board_q[i + 4'd1]) has_pair = 1'b1;
        if (r < 3 && board_q[i] == board_q[i + 4'd4]) has_pair = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    score_d   = score_q;
    dir_d     = dir_q;
    invalid_d = 1'b0;
    won_d     = won_q;
    over_d    = over_q;
    if (bus.start) begin
      state_d = SPAWN_A;
      board_d = '0;
      score_d = '0;
      won_d   = 1'b0;
      over_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.load_valid) begin
            board_d = load_flat;
            state_d = WAIT;
          end
        end
        SPAWN_A: begin
          board_d = spawned;
          state_d = SPAWN_B;
        end
        SPAWN_B: begin
          board_d = spawned;
          state_d = WAIT;
        end
        WAIT: begin
          if (bus.load_valid) begin
            board_d = load_flat;
          end else if (accept) begin
            if ($onehot(bus.direction)) begin
              dir_d   = bus.direction;
              state_d = APPLY;
            end else begin
              invalid_d = 1'b1;
            end
          end
        end
        APPLY: begin
          if (mm_out == board_q) begin
            invalid_d = 1'b1;
            state_d   = WAIT;
          end else begin
            board_d = mm_out;
            score_d = score_sum[20] ? '1 : score_sum[19:0];
            state_d = SPAWN;
          end
        end
        SPAWN: begin
          board_d = spawned;
          state_d = CHECK;
        end
        CHECK: begin
          if (has_win_tile) won_d = 1'b1;
          if (full && !has_pair) begin
            over_d  = 1'b1;
            state_d = LOST;
          end else begin
            state_d = WAIT;
          end
        end
        LOST: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      board_q     <= '0;
      score_q     <= '0;
      dir_q       <= '0;
      dir_ready_q <= 1'b0;
      invalid_q   <= 1'b0;
      won_q       <= 1'b0;
      over_q      <= 1'b0;
      lfsr_q      <= 16'hACE1;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      score_q     <= score_d;
      dir_q       <= dir_d;
      // Registered from next state so it is high exactly while state is WAIT.
      dir_ready_q <= (state_d == WAIT);
      invalid_q   <= invalid_d;
      won_q       <= won_d;
      over_q      <= over_d;
      lfsr_q      <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign bus.dir_ready    = dir_ready_q;
  assign bus.mm_direction = dir_q;
  assign bus.mm_board_in  = board_q;
  assign bus.board        = board_q;
  assign bus.score        = score_q;
  assign bus.move_invalid = invalid_q;
  assign bus.game_won     = won_q;
  assign bus.game_over    = over_q;

endmodule

// File: tb/tb_game_fsm_ctrl.sv
// Scoreboard bench for game_fsm_ctrl: a 2048 line-merge model stands in for the
// datapath and predicts each response, which a separate monitor compares.
module tb_game_fsm_ctrl;
  typedef logic [15:0][11:0] brd_t;
  typedef struct {
    bit          inv;
    brd_t        b;
    logic [19:0] s;
    bit          won;
    bit          over;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  game_fsm_ctrl_if bus ();
  game_fsm_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  exp_t q[$];
  brd_t m_board;
  logic [19:0] m_score;
  bit m_won, m_over;
  logic [19:0] boost;
  logic [15:0] tb_lfsr;

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_lfsr <= 16'hACE1;
    else        tb_lfsr <= step(tb_lfsr);

  // k-th cell of line ln, counted from the wall the tiles move toward
  function automatic int pos(input logic [3:0] d, input int ln, input int k);
    case (d)
      4'b0001: return k * 4 + ln;
      4'b0010: return (3 - k) * 4 + ln;
      4'b0100: return ln * 4 + k;
      default: return ln * 4 + (3 - k);
    endcase
  endfunction

  function automatic void slide(input brd_t b, input logic [3:0] d,
                                output brd_t nb, output logic [19:0] inc);
    nb  = b;
    inc = '0;
    if (!$onehot(d)) return;
    for (int ln = 0; ln < 4; ln++) begin
      logic [11:0] vals[$];
      logic [11:0] outv[$];
      int j;
      for (int k = 0; k < 4; k++)
        if (b[pos(d, ln, k)] != 12'h0) vals.push_back(b[pos(d, ln, k)]);
      j = 0;
      while (j < vals.size()) begin
        if (j + 1 < vals.size() && vals[j] == vals[j + 1]) begin
          outv.push_back(vals[j] << 1);
          inc = inc + {7'd0, vals[j], 1'b0};
          j = j + 2;
        end else begin
          outv.push_back(vals[j]);
          j = j + 1;
        end
      end
      for (int k = 0; k < 4; k++)
        nb[pos(d, ln, k)] = (k < outv.size()) ? outv[k] : 12'h0;
    end
  endfunction

  function automatic brd_t spawn(input brd_t b, input logic [15:0] l);
    brd_t r = b;
    for (int k = 0; k < 16; k++) begin
      int idx = (int'(l[3:0]) + k) % 16;
      if (r[idx] == 12'h0) begin
        r[idx] = (l[7:4] == 4'd0) ? 12'h004 : 12'h002;
        return r;
      end
    end
    return r;
  endfunction

  function automatic bit stuck(input brd_t b);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (b[r*4+c] == 12'h0) return 1'b0;
        if (c < 3 && b[r*4+c] == b[r*4+c+1]) return 1'b0;
        if (r < 3 && b[r*4+c] == b[r*4+c+4]) return 1'b0;
      end
    return 1'b1;
  endfunction

  function automatic bit has800(input brd_t b);
    for (int i = 0; i < 16; i++) if (b[i] == 12'h800) return 1'b1;
    return 1'b0;
  endfunction

  function automatic brd_t put_row(input brd_t b, input int r,
                                   input logic [11:0] c0, c1, c2, c3);
    brd_t x = b;
    x[r*4] = c0; x[r*4+1] = c1; x[r*4+2] = c2; x[r*4+3] = c3;
    return x;
  endfunction

  function automatic brd_t rand_board();
    brd_t b;
    for (int i = 0; i < 16; i++)
      b[i] = ($urandom_range(0, 3) == 0) ? 12'h0 : 12'(1 << $urandom_range(1, 7));
    return b;
  endfunction

  // Datapath stand-in; boost lets the bench push the score toward saturation.
  brd_t dp_out;
  logic [19:0] dp_inc;
  always_comb slide(brd_t'(bus.mm_board_in), bus.mm_direction, dp_out, dp_inc);
  assign bus.mm_board_out    = dp_out;
  assign bus.mm_score_update = dp_inc + boost;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic chk_b(input string name, input brd_t act, input brd_t want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  bit prev_ready = 1'b0;
  bit prev_over  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (bus.move_invalid || (bus.dir_ready && !prev_ready) ||
                  (bus.game_over && !prev_over))) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_event: got inv=%0b rdy=%0b over=%0b want no event",
                 bus.move_invalid, bus.dir_ready, bus.game_over);
      end else begin
        e = q.pop_front();
        chk("event_kind", 32'(bus.move_invalid), 32'(e.inv));
        chk_b("board", brd_t'(bus.board), e.b);
        chk("score", 32'(bus.score), 32'(e.s));
        chk("game_won", 32'(bus.game_won), 32'(e.won));
        chk("game_over", 32'(bus.game_over), 32'(e.over));
        chk("dir_ready", 32'(bus.dir_ready), 32'(!e.over));
      end
    end
    prev_ready = bus.dir_ready;
    prev_over  = bus.game_over;
  end

  task automatic push_state(input bit inv);
    exp_t e;
    e.inv = inv; e.b = m_board; e.s = m_score; e.won = m_won; e.over = m_over;
    q.push_back(e);
  endtask

  task automatic wait_settle(input string name);
    int n = 0;
    while ((q.size() != 0 || !(bus.dir_ready || bus.game_over)) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      total++; bad++;
      $display("FAIL %s_timeout: got %0d pending want 0", name, q.size());
    end
  endtask

  task automatic cycles_to_ready(output int n);
    n = 0;
    while (!bus.dir_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_start();
    logic [15:0] l = tb_lfsr;
    m_board = spawn(spawn('0, step(l)), step(step(l)));
    m_score = '0; m_won = 1'b0; m_over = 1'b0;
    push_state(1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic issue_move(input logic [3:0] d);
    brd_t nb;
    logic [19:0] inc;
    logic [20:0] sum;
    logic [15:0] l;
    wait_settle("pre_move");
    if (!bus.dir_ready) return;
    l = tb_lfsr;
    slide(m_board, d, nb, inc);
    if (!$onehot(d) || nb == m_board) begin
      push_state(1'b1);
    end else begin
      m_board = spawn(nb, step(step(l)));
      sum     = {1'b0, m_score} + {1'b0, inc} + {1'b0, boost};
      m_score = sum[20] ? 20'hFFFFF : sum[19:0];
      m_won   = m_won | has800(m_board);
      m_over  = stuck(m_board);
      push_state(1'b0);
    end
    bus.dir_valid = 1'b1;
    bus.direction = d;
    @(negedge clk);
    bus.dir_valid = 1'b0;
    bus.direction = '0;
  endtask

  task automatic load_wait(input brd_t b, input bit with_dir);
    wait_settle("pre_load");
    m_board = b;
    bus.load_valid = 1'b1;
    bus.load_board = b;
    bus.dir_valid  = with_dir;
    bus.direction  = 4'b0100;
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.dir_valid  = 1'b0;
    bus.direction  = '0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_board0"}, 32'(bus.board == '0), 32'd1);
    chk({tag, "_score"}, 32'(bus.score), 32'd0);
    chk({tag, "_ready"}, 32'(bus.dir_ready), 32'd0);
    chk({tag, "_invalid"}, 32'(bus.move_invalid), 32'd0);
    chk({tag, "_won"}, 32'(bus.game_won), 32'd0);
    chk({tag, "_over"}, 32'(bus.game_over), 32'd0);
    chk({tag, "_mmdir"}, 32'(bus.mm_direction), 32'd0);
  endtask

  task automatic two_tile_check();
    int nz = 0, ok = 0;
    brd_t b = bus.board;
    for (int i = 0; i < 16; i++)
      if (b[i] != 12'h0) begin
        nz++;
        if (b[i] == 12'h2 || b[i] == 12'h4) ok++;
      end
    chk("start_tiles", 32'(nz), 32'd2);
    chk("start_tile_vals", 32'(ok), 32'd2);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish want finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1);
  end

  initial begin
    brd_t b, pre, cur;
    int n, diff, dok;
    logic [3:0] d;
    logic [3:0] dirs[4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    bus.start = 1'b0; bus.dir_valid = 1'b0; bus.direction = '0;
    bus.load_valid = 1'b0; bus.load_board = '0;
    boost = '0;
    m_board = '0; m_score = '0; m_won = 1'b0; m_over = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Preload from IDLE, then the up merge
    b = put_row('0, 0, 12'h2, 12'h2, 12'h4, 12'h4);
    b = put_row(b, 1, 12'h2, 12'h2, 12'h4, 12'h4);
    b = put_row(b, 2, 12'h0, 12'h0, 12'h4, 12'h0);
    b = put_row(b, 3, 12'h0, 12'h0, 12'h4, 12'h0);
    m_board = b;
    push_state(1'b0);
    bus.load_valid = 1'b1; bus.load_board = b;
    @(negedge clk);
    bus.load_valid = 1'b0;
    wait_settle("idle_load");
    issue_move(4'b0001);
    cycles_to_ready(n);
    chk("up_ready_latency", 32'(n), 32'd3);
    wait_settle("up");
    pre = put_row('0, 0, 12'h4, 12'h4, 12'h8, 12'h8);
    pre = put_row(pre, 1, 12'h0, 12'h0, 12'h8, 12'h0);
    cur = bus.board;
    diff = 0; dok = 0;
    for (int i = 0; i < 16; i++)
      if (cur[i] != pre[i]) begin
        diff++;
        if (pre[i] == 12'h0 && (cur[i] == 12'h2 || cur[i] == 12'h4)) dok++;
      end
    chk("up_new_tiles", 32'(diff), 32'd1);
    chk("up_new_tile_ok", 32'(dok), 32'd1);
    chk("up_score", 32'(bus.score), 32'h20);
    chk("up_mmdir", 32'(bus.mm_direction), 32'b0001);

    // No-op move, illegal code, load racing a command
    load_wait(put_row('0, 0, 12'h2, 12'h0, 12'h0, 12'h0), 1'b1);
    issue_move(4'b0001);
    cycles_to_ready(n);
    chk("noop_ready_latency", 32'(n), 32'd1);
    wait_settle("noop");
    issue_move(4'b0011);
    chk("illegal_stays_ready", 32'(bus.dir_ready), 32'd1);
    chk("illegal_pulse", 32'(bus.move_invalid), 32'd1);
    wait_settle("illegal");

    // Game over: only merge fills the board with no pairs
    b = put_row('0, 0, 12'h2, 12'h4, 12'h2, 12'h4);
    b = put_row(b, 1, 12'h4, 12'h2, 12'h4, 12'h2);
    b = put_row(b, 2, 12'h2, 12'h4, 12'h2, 12'h80);
    b = put_row(b, 3, 12'h8, 12'h8, 12'h20, 12'h40);
    load_wait(b, 1'b0);
    issue_move(4'b0100);
    wait_settle("over");
    chk("over_flag", 32'(bus.game_over), 32'd1);
    chk("over_not_ready", 32'(bus.dir_ready), 32'd0);
    bus.dir_valid = 1'b1; bus.direction = 4'b0001;
    bus.load_valid = 1'b1; bus.load_board = rand_board();
    repeat (5) @(negedge clk);
    bus.dir_valid = 1'b0; bus.load_valid = 1'b0;
    chk_b("lost_board_held", brd_t'(bus.board), m_board);
    chk("lost_still_over", 32'(bus.game_over), 32'd1);
    do_start();
    wait_settle("restart");
    two_tile_check();

    // Win, continued play, score saturation
    load_wait(put_row('0, 0, 12'h400, 12'h400, 12'h0, 12'h0), 1'b0);
    issue_move(4'b0100);
    wait_settle("win");
    chk("won_flag", 32'(bus.game_won), 32'd1);
    boost = 20'h80000;
    for (int k = 0; k < 8 && m_score != 20'hFFFFF; k++) begin
      issue_move(dirs[k % 4]);
      wait_settle("sat");
    end
    chk("score_saturated", 32'(bus.score), 32'hFFFFF);
    chk("won_sticky", 32'(bus.game_won), 32'd1);
    boost = '0;

    // Start the cycle after a command is accepted
    wait_settle("pre_abort");
    bus.dir_valid = 1'b1; bus.direction = 4'b0100;
    @(negedge clk);
    bus.dir_valid = 1'b0; bus.direction = '0;
    do_start();
    wait_settle("abort");
    chk("abort_score", 32'(bus.score), 32'd0);

    // Randomised play
    for (int k = 0; k < 250; k++) begin
      wait_settle("rand");
      if (m_over) begin
        do_start();
        continue;
      end
      n = int'($urandom_range(0, 19));
      if (n == 0) begin
        load_wait(rand_board(), $urandom_range(0, 1) == 1);
      end else if (n == 1) begin
        d = 4'($urandom_range(0, 15));
        while ($onehot(d)) d = 4'($urandom_range(0, 15));
        issue_move(d);
      end else if (n == 2) begin
        do_start();
      end else begin
        issue_move(dirs[$urandom_range(0, 3)]);
      end
    end
    wait_settle("rand_end");

    // Asynchronous reset mid-game
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    q.delete();
    m_board = '0; m_score = '0; m_won = 1'b0; m_over = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    cycles_to_ready(n);
    chk("start_ready_latency", 32'(n), 32'd2);
    wait_settle("post_reset");
    two_tile_check();
    chk("post_reset_score", 32'(bus.score), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
